// File: rtl/sid_audio_pkg.sv
// Shared constants for the SID audio output path: sample width, I2S channel
// encoding and default serialiser timing.
package sid_audio_pkg;

  localparam int SID_SAMPLE_W   = 16;
  localparam int DEF_BCLK_DIV   = 8;
  localparam int DEF_SLOT_BITS  = 32;

  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } i2s_ch_e;

endpackage

// File: rtl/sid_i2s_tx_if.sv
// Sample-in / I2S-out bundle of the SID serial audio stage.
interface sid_i2s_tx_if
  import sid_audio_pkg::*;
  ();

  logic signed [SID_SAMPLE_W-1:0] SAMPLE;
  logic                           MUTE;
  logic                           I2S_BCLK;
  logic                           I2S_LRCLK;
  logic                           I2S_DATA;
  logic                           FRAME_STROBE;

  modport master (
    output SAMPLE, MUTE,
    input  I2S_BCLK, I2S_LRCLK, I2S_DATA, FRAME_STROBE
  );

  modport slave (
    input  SAMPLE, MUTE,
    output I2S_BCLK, I2S_LRCLK, I2S_DATA, FRAME_STROBE
  );

endinterface

// File: rtl/sid_i2s_clkgen.sv
// BCLK/LRCLK generator: master-clock divider plus frame bit counter, with
// falling-edge and frame-start event flags for the data path.
module sid_i2s_clkgen
  import sid_audio_pkg::*;
#(
  parameter int BCLK_DIV  = DEF_BCLK_DIV,
  parameter int SLOT_BITS = DEF_SLOT_BITS,
  localparam int PW       = $clog2(SLOT_BITS)
) (
  input  logic          clk,
  input  logic          rst,
  output logic          bclk,
  output logic          lrclk,
  output logic          fall_evt,
  output logic          frame_start,
  output logic [PW-1:0] slot_pos
);

  localparam int FRAME_BITS = 2 * SLOT_BITS;
  localparam int BW         = $clog2(FRAME_BITS);
  localparam int DW         = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

  logic [DW-1:0] div_cnt;
  logic [BW-1:0] bit_cnt;
  logic [BW-1:0] bit_nxt;
  logic          toggle;
  logic          wrap;

  assign toggle      = (div_cnt == DW'(BCLK_DIV - 1));
  assign fall_evt    = toggle & bclk;
  assign wrap        = (bit_cnt == BW'(FRAME_BITS - 1));
  assign frame_start = fall_evt & wrap;
  assign bit_nxt     = wrap ? '0 : bit_cnt + 1'b1;

  // Position within the slot that the coming falling edge will present.
  assign slot_pos = (bit_nxt >= BW'(SLOT_BITS)) ? PW'(bit_nxt - BW'(SLOT_BITS))
                                                : PW'(bit_nxt);

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
      lrclk   <= CH_RIGHT;
      bit_cnt <= BW'(FRAME_BITS - 1);
    end else begin
      div_cnt <= toggle ? '0 : div_cnt + 1'b1;
      if (toggle) bclk <= ~bclk;
      if (fall_evt) begin
        bit_cnt <= bit_nxt;
        lrclk   <= (bit_nxt >= BW'(SLOT_BITS));
      end
    end
  end

endmodule

// File: rtl/sid_i2s_tx.sv
// Philips I2S transmitter for the SID core output: one held mono sample per
// frame, sent MSB first in both the left and right slots.
module sid_i2s_tx
  import sid_audio_pkg::*;
#(
  parameter int BCLK_DIV    = DEF_BCLK_DIV,
  parameter int SLOT_BITS   = DEF_SLOT_BITS,
  parameter int SAMPLE_BITS = SID_SAMPLE_W
) (
  input  logic         CLK,
  input  logic         RST,
  sid_i2s_tx_if.slave  bus
);

  localparam int PW = $clog2(SLOT_BITS);
  localparam int SW = $clog2(SAMPLE_BITS);

  if (BCLK_DIV < 1 || SLOT_BITS <= SAMPLE_BITS || SAMPLE_BITS != SID_SAMPLE_W) begin : g_param_check
    $error("sid_i2s_tx: illegal BCLK_DIV/SLOT_BITS/SAMPLE_BITS combination");
  end

  logic                          bclk;
  logic                          lrclk;
  logic                          fall_evt;
  logic                          frame_start;
  logic [PW-1:0]                 slot_pos;
  logic signed [SAMPLE_BITS-1:0] hold;
  logic                          data;
  logic                          strobe;

  // Slot position 0 is the I2S delay bit; positions past the word are padding.
  function automatic logic slot_bit(input logic [SAMPLE_BITS-1:0] word,
                                    input logic [PW-1:0]          pos);
    logic bit_v;
    bit_v = 1'b0;
    if (pos != '0 && int'(pos) <= SAMPLE_BITS)
      bit_v = word[SW'(SAMPLE_BITS - int'(pos))];
    return bit_v;
  endfunction

  sid_i2s_clkgen #(
    .BCLK_DIV  (BCLK_DIV),
    .SLOT_BITS (SLOT_BITS)
  ) u_clkgen (
    .clk         (CLK),
    .rst         (RST),
    .bclk        (bclk),
    .lrclk       (lrclk),
    .fall_evt    (fall_evt),
    .frame_start (frame_start),
    .slot_pos    (slot_pos)
  );

  // Frame latch and serial data register, both updated on BCLK falling events.
  always_ff @(posedge CLK) begin
    if (RST) begin
      hold   <= '0;
      data   <= 1'b0;
      strobe <= 1'b0;
    end else begin
      strobe <= frame_start;
      if (frame_start) hold <= bus.MUTE ? '0 : bus.SAMPLE;
      if (fall_evt)    data <= slot_bit(hold, slot_pos);
    end
  end

  assign bus.I2S_BCLK     = bclk;
  assign bus.I2S_LRCLK    = lrclk;
  assign bus.I2S_DATA     = data;
  assign bus.FRAME_STROBE = strobe;

endmodule

// File: tb/tb_sid_i2s_tx.sv
// Bench for sid_i2s_tx: an arithmetic frame-timing model checked every cycle,
// plus directed frames with hand-computed words and timing literals.
module tb_sid_i2s_tx;
  import sid_audio_pkg::*;

  typedef struct packed {
    logic bclk;
    logic lr;
    logic data;
    logic stb;
  } exp_t;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  int   total_cnt = 0;
  int   pass_cnt  = 0;

  always #5 clk = ~clk;

  sid_i2s_tx_if bus_a ();
  sid_i2s_tx_if bus_b ();

  sid_i2s_tx #(.BCLK_DIV(2), .SLOT_BITS(32), .SAMPLE_BITS(16)) dut_a (
    .CLK (clk), .RST (rst_a), .bus (bus_a)
  );

  sid_i2s_tx #(.BCLK_DIV(1), .SLOT_BITS(17), .SAMPLE_BITS(16)) dut_b (
    .CLK (clk), .RST (rst_b), .bus (bus_b)
  );

  task automatic chk(input string nm, input logic act, input logic exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
  endtask

  task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  // Outputs after the k-th CLK edge since reset release, from frame arithmetic.
  function automatic exp_t model_out(input int k, input int d, input int s, input logic [15:0] h);
    exp_t e;
    int f, b, p;
    logic [15:0] t;
    e = '{bclk: 1'b0, lr: 1'b1, data: 1'b0, stb: 1'b0};
    if (k > 0) begin
      e.bclk = ((k / d) % 2) == 1;
      f = k / (2 * d);
      if (f > 0) begin
        b    = (f - 1) % (2 * s);
        e.lr = (b >= s);
        p    = b % s;
        if (p >= 1 && p <= 16) begin
          t      = h >> (16 - p);
          e.data = t[0];
        end
        e.stb = ((k % (2 * d)) == 0) && (b == 0);
      end
    end
    return e;
  endfunction

  function automatic logic is_latch(input int k, input int d, input int s);
    return (k > 0) && ((k % (2 * d)) == 0) && (k / (2 * d) > 0) &&
           (((k / (2 * d) - 1) % (2 * s)) == 0);
  endfunction

  int          k_a = 0, k_b = 0;
  logic [15:0] h_a = '0, h_b = '0;
  logic        pb_a = 1'b0, pl_a = 1'b1, pd_a = 1'b0;
  exp_t        e_a, e_b;

  always @(posedge clk) begin
    #1;
    if (rst_a) begin
      k_a = 0; h_a = '0;
    end else begin
      k_a++;
      if (is_latch(k_a, 2, 32)) h_a = bus_a.MUTE ? 16'h0 : bus_a.SAMPLE;
    end
    e_a = model_out(k_a, 2, 32, h_a);
    chk("a_bclk",   bus_a.I2S_BCLK,     e_a.bclk);
    chk("a_lrclk",  bus_a.I2S_LRCLK,    e_a.lr);
    chk("a_data",   bus_a.I2S_DATA,     e_a.data);
    chk("a_strobe", bus_a.FRAME_STROBE, e_a.stb);
    if (!rst_a && !pb_a && bus_a.I2S_BCLK) begin
      chk("a_lrclk_stable_on_rise", bus_a.I2S_LRCLK, pl_a);
      chk("a_data_stable_on_rise",  bus_a.I2S_DATA,  pd_a);
    end
    pb_a = bus_a.I2S_BCLK; pl_a = bus_a.I2S_LRCLK; pd_a = bus_a.I2S_DATA;

    if (rst_b) begin
      k_b = 0; h_b = '0;
    end else begin
      k_b++;
      if (is_latch(k_b, 1, 17)) h_b = bus_b.MUTE ? 16'h0 : bus_b.SAMPLE;
    end
    e_b = model_out(k_b, 1, 17, h_b);
    chk("b_bclk",   bus_b.I2S_BCLK,     e_b.bclk);
    chk("b_lrclk",  bus_b.I2S_LRCLK,    e_b.lr);
    chk("b_data",   bus_b.I2S_DATA,     e_b.data);
    chk("b_strobe", bus_b.FRAME_STROBE, e_b.stb);
  end

  function automatic logic stb_of(input int which);
    return which != 0 ? bus_b.FRAME_STROBE : bus_a.FRAME_STROBE;
  endfunction

  task automatic drive(input int which, input logic [15:0] s, input logic m);
    if (which != 0) begin bus_b.SAMPLE = s; bus_b.MUTE = m; end
    else            begin bus_a.SAMPLE = s; bus_a.MUTE = m; end
  endtask

  task automatic wait_strobe(input int which, input int limit, output int n);
    n = 0;
    for (int i = 0; i < limit; i++) begin
      @(posedge clk); #2;
      n++;
      if (stb_of(which)) break;
    end
  endtask

  // Walks one frame from a latch edge, collecting the word bits of both slots.
  task automatic capture(input int which, input int d, input int s,
                         input logic [15:0] mid_s, input logic pulse, input logic mute_next,
                         output logic [15:0] l, output logic [15:0] r, output int stray);
    int b, p;
    logic dv;
    l = '0; r = '0; stray = 0;
    for (int f = 1; f <= 2 * s; f++) begin
      repeat (2 * d) @(posedge clk);
      #2;
      dv = (which != 0) ? bus_b.I2S_DATA : bus_a.I2S_DATA;
      b  = f % (2 * s);
      p  = b % s;
      if (p >= 1 && p <= 16) begin
        if (b < s) l[4'(16 - p)] = dv;
        else       r[4'(16 - p)] = dv;
      end else if (dv) begin
        stray++;
      end
      if (which == 0 && f == 40) begin
        bus_a.SAMPLE = mid_s;
        if (pulse) bus_a.MUTE = 1'b1;
      end
      if (which == 0 && f == 45 && pulse) bus_a.MUTE = 1'b0;
      if (which == 0 && f == 50) bus_a.MUTE = mute_next;
    end
  endtask

  task automatic frame_check(input string nm, input int which, input int d, input int s,
                             input logic [15:0] mid_s, input logic pulse, input logic mute_next,
                             input logic [15:0] exp_word);
    logic [15:0] l, r;
    int stray;
    capture(which, d, s, mid_s, pulse, mute_next, l, r, stray);
    chk16({nm, "_left"},  l, exp_word);
    chk16({nm, "_right"}, r, exp_word);
    chk_int({nm, "_pad_zero"}, stray, 0);
    chk({nm, "_next_strobe"}, stb_of(which), 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    drive(0, 16'hA5C3, 1'b0);
    drive(1, 16'h0001, 1'b0);

    repeat (5) @(posedge clk);
    #2;
    chk("a_reset_bclk",   bus_a.I2S_BCLK,     1'b0);
    chk("a_reset_lrclk",  bus_a.I2S_LRCLK,    1'b1);
    chk("a_reset_data",   bus_a.I2S_DATA,     1'b0);
    chk("a_reset_strobe", bus_a.FRAME_STROBE, 1'b0);
    rst_a = 1'b0;

    wait_strobe(0, 20, n);
    chk_int("a_first_strobe_edge", n, 4);
    chk("a_first_strobe_lrclk", bus_a.I2S_LRCLK, 1'b0);

    frame_check("a_a5c3", 0, 2, 32, 16'hA5C3, 1'b0, 1'b0, 16'hA5C3);
    bus_a.SAMPLE = 16'h7FFF;
    frame_check("a_a5c3_isolated", 0, 2, 32, 16'h7FFF, 1'b0, 1'b0, 16'hA5C3);
    frame_check("a_7fff", 0, 2, 32, 16'h8000, 1'b1, 1'b0, 16'h7FFF);
    frame_check("a_8000", 0, 2, 32, 16'h8000, 1'b0, 1'b1, 16'h8000);
    frame_check("a_muted", 0, 2, 32, 16'hFFFF, 1'b0, 1'b0, 16'h0000);

    // Abort the FFFF frame at right-slot position 9.
    repeat (40 * 4) @(posedge clk);
    repeat (3) @(posedge clk);
    #2;
    chk("a_pre_reset_data", bus_a.I2S_DATA, 1'b1);
    rst_a = 1'b1;
    bus_a.SAMPLE = 16'hC35A;
    @(posedge clk);
    #2;
    chk("a_midreset_bclk",   bus_a.I2S_BCLK,     1'b0);
    chk("a_midreset_lrclk",  bus_a.I2S_LRCLK,    1'b1);
    chk("a_midreset_data",   bus_a.I2S_DATA,     1'b0);
    chk("a_midreset_strobe", bus_a.FRAME_STROBE, 1'b0);
    @(posedge clk);
    #2;
    rst_a = 1'b0;
    wait_strobe(0, 20, n);
    chk_int("a_restart_strobe_edge", n, 4);
    frame_check("a_c35a_after_reset", 0, 2, 32, 16'hC35A, 1'b0, 1'b0, 16'hC35A);

    rst_b = 1'b0;
    wait_strobe(1, 10, n);
    chk_int("b_first_strobe_edge", n, 2);
    frame_check("b_0001", 1, 1, 17, 16'h0001, 1'b0, 1'b0, 16'h0001);
    bus_b.SAMPLE = 16'h8001;
    frame_check("b_0001_isolated", 1, 1, 17, 16'h8001, 1'b0, 1'b0, 16'h0001);
    frame_check("b_8001", 1, 1, 17, 16'h8001, 1'b0, 1'b0, 16'h8001);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
